// File: rtl/mist1032isa_sync_fifo.sv
// mist1032isa_sync_fifo
//   Single-clock first-word-fall-through FIFO. The head entry is always
//   presented on oRD_DATA; asserting iRD_EN consumes it on the next edge.
//
// Parameters
//   N        data width in bits
//   DEPTH    number of entries (must equal 2**DEPTH_N)
//   DEPTH_N  pointer width
//
// Ports
//   iCLOCK       clock, all state updates on the rising edge
//   iRESET_SYNC  synchronous active-high reset (pointers and count only)
//   oCOUNT       number of valid entries, 0..DEPTH
//   iWR_EN       push iWR_DATA this cycle (dropped when full)
//   iWR_DATA     data to push
//   oWR_FULL     FIFO holds DEPTH entries
//   iRD_EN       pop head entry this cycle (ignored when empty)
//   oRD_DATA     current head entry, combinational from storage
//   oRD_EMPTY    FIFO holds no entries
module mist1032isa_sync_fifo #(
  parameter int N       = 16,
  parameter int DEPTH   = 4,
  parameter int DEPTH_N = 2
) (
  input  logic               iCLOCK,
  input  logic               iRESET_SYNC,
  output logic [DEPTH_N:0]   oCOUNT,
  input  logic               iWR_EN,
  input  logic [N-1:0]       iWR_DATA,
  output logic               oWR_FULL,
  input  logic               iRD_EN,
  output logic [N-1:0]       oRD_DATA,
  output logic               oRD_EMPTY
);

  localparam logic [DEPTH_N:0]   FULL_CNT = (DEPTH_N+1)'(DEPTH);
  localparam logic [DEPTH_N:0]   CNT_ONE  = (DEPTH_N+1)'(1);
  localparam logic [DEPTH_N-1:0] PTR_ONE  = DEPTH_N'(1);

  logic [N-1:0]       mem_q [DEPTH];
  logic [DEPTH_N-1:0] wptr_q, wptr_d;
  logic [DEPTH_N-1:0] rptr_q, rptr_d;
  logic [DEPTH_N:0]   count_q, count_d;
  logic               we, re;

  // Full/empty come from the registered count, so a same-cycle read never
  // makes room for a write to a full FIFO and vice versa.
  assign oRD_EMPTY = (count_q == '0);
  assign oWR_FULL  = (count_q == FULL_CNT);
  assign oCOUNT    = count_q;
  assign oRD_DATA  = mem_q[rptr_q];

  assign we = iWR_EN && !oWR_FULL;
  assign re = iRD_EN && !oRD_EMPTY;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (we) wptr_d = wptr_q + PTR_ONE;
    if (re) rptr_d = rptr_q + PTR_ONE;
    if (we && !re)      count_d = count_q + CNT_ONE;
    else if (re && !we) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; gating on reset keeps writes from landing while
  // the pointers are being cleared.
  always_ff @(posedge iCLOCK) begin
    if (!iRESET_SYNC && we) mem_q[wptr_q] <= iWR_DATA;
  end

endmodule

// File: tb/tb_mist1032isa_sync_fifo.sv
module tb_mist1032isa_sync_fifo;

  localparam int N = 64;
  localparam int DEPTH = 8;
  localparam int DEPTH_N = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [DEPTH_N:0] count;
  logic           wr_en;
  logic [N-1:0]   wr_data;
  logic           full;
  logic           rd_en;
  logic [N-1:0]   rd_data;
  logic           empty;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [N-1:0] sb [$];

  mist1032isa_sync_fifo #(.N(N), .DEPTH(DEPTH), .DEPTH_N(DEPTH_N)) dut (
    .iCLOCK(clk),
    .iRESET_SYNC(rst),
    .oCOUNT(count),
    .iWR_EN(wr_en),
    .iWR_DATA(wr_data),
    .oWR_FULL(full),
    .iRD_EN(rd_en),
    .oRD_DATA(rd_data),
    .oRD_EMPTY(empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_count"}, N'(count), N'(sb.size()));
    chk({tag, "_empty"}, N'(empty), N'(sb.size() == 0));
    chk({tag, "_full"},  N'(full),  N'(sb.size() == DEPTH));
    if (sb.size() != 0) chk({tag, "_head"}, rd_data, sb[0]);
  endtask

  // One clock: drive at negedge, check popped data before the edge,
  // update the scoreboard on the edge, check status just after it.
  task automatic cyc(input logic wr, input logic [N-1:0] d, input logic rd, input string tag);
    logic do_we, do_re;
    @(negedge clk);
    rst = 1'b0; wr_en = wr; wr_data = d; rd_en = rd;
    #1;
    do_we = wr && (sb.size() < DEPTH);
    do_re = rd && (sb.size() > 0);
    if (do_re) chk({tag, "_pop"}, rd_data, sb[0]);
    @(posedge clk);
    if (do_re) void'(sb.pop_front());
    if (do_we) sb.push_back(d);
    #1;
    chk_status(tag);
  endtask

  task automatic reset_cyc(input string tag);
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b1; wr_data = 64'hDEAD; rd_en = 1'b0;
    @(posedge clk);
    sb.delete();
    #1;
    chk({tag, "_count"}, N'(count), '0);
    chk({tag, "_empty"}, N'(empty), N'(1));
    chk({tag, "_full"},  N'(full),  N'(0));
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;

    reset_cyc("rst0");
    reset_cyc("rst1");

    // Fall-through
    cyc(1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, "ft_push");
    chk("ft_data", rd_data, 64'h0123_4567_89AB_CDEF);
    chk("ft_cnt", N'(count), N'(1));
    cyc(1'b0, '0, 1'b1, "ft_pop");
    chk("ft_empty", N'(empty), N'(1));

    // Fill and overflow
    for (int i = 1; i <= 9; i++) cyc(1'b1, N'(i), 1'b0, "fill");
    chk("fill_full", N'(full), N'(1));
    chk("fill_cnt", N'(count), N'(8));
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", rd_data, N'(i));
      cyc(1'b0, '0, 1'b1, "drain");
    end
    chk("drain_empty", N'(empty), N'(1));

    // Underflow
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, "uflow");
    chk("uflow_cnt", N'(count), '0);
    cyc(1'b1, N'(5), 1'b0, "uf_push");
    chk("uf_head", rd_data, N'(5));
    cyc(1'b0, '0, 1'b1, "uf_pop");

    // Simultaneous read/write at count 3
    for (int i = 10; i <= 12; i++) cyc(1'b1, N'(i), 1'b0, "s3_fill");
    cyc(1'b1, N'(13), 1'b1, "s3_both");
    chk("s3_cnt", N'(count), N'(3));
    chk("s3_head", rd_data, N'(11));
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, "s3_drain");

    // Full with both asserted: write dropped
    for (int i = 20; i < 28; i++) cyc(1'b1, N'(i), 1'b0, "sf_fill");
    cyc(1'b1, N'(99), 1'b1, "sf_both");
    chk("sf_cnt", N'(count), N'(7));
    for (int i = 21; i < 28; i++) begin
      chk("sf_order", rd_data, N'(i));
      cyc(1'b0, '0, 1'b1, "sf_drain");
    end
    chk("sf_empty", N'(empty), N'(1));

    // Empty with both asserted: read ignored
    cyc(1'b1, N'(77), 1'b1, "se_both");
    chk("se_cnt", N'(count), N'(1));
    chk("se_head", rd_data, N'(77));
    cyc(1'b0, '0, 1'b1, "se_pop");

    // Wrap-around at count 4
    for (int i = 0; i < 4; i++) cyc(1'b1, N'(100 + i), 1'b0, "wr_prime");
    for (int i = 0; i < 20; i++) begin
      chk("wrap_lag", rd_data, N'(100 + i));
      cyc(1'b1, N'(104 + i), 1'b1, "wrap");
    end
    chk("wrap_cnt", N'(count), N'(4));

    // Reset mid-operation discards entries
    reset_cyc("rst_mid");
    cyc(1'b1, N'(55), 1'b0, "post_rst");
    chk("post_rst_head", rd_data, N'(55));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
